// File: rtl/keypad_entry_buffer.sv
// Keypad entry buffer: turns each debounced key press into exactly one action
// on an N-digit shift-in buffer with clear/backspace/enter, plus a commit port.
module keypad_entry_buffer #(
    parameter int         NUM_DIGITS = 4,
    parameter int         REL_CYCLES = 16,
    parameter int         DEC_ONLY   = 0,
    parameter logic [3:0] KEY_ENTER  = 4'hE,
    parameter logic [3:0] KEY_CLEAR  = 4'hC,
    parameter logic [3:0] KEY_BACK   = 4'hB
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_active,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    output logic [4*NUM_DIGITS-1:0]           buf_data,
    output logic [NUM_DIGITS-1:0]             buf_en,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic [4*NUM_DIGITS-1:0]           commit_data,
    output logic                              commit_valid,
    output logic                              reject
);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int RW = $clog2(REL_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTION, S_WAIT_REL} state_t;

    state_t            r_state,  w_state_nxt;
    logic [3:0]        r_code,   w_code_nxt;
    logic [RW-1:0]     r_rel,    w_rel_nxt;
    logic [DW-1:0]     r_buf,    w_buf_nxt;
    logic [NUM_DIGITS-1:0] r_en, w_en_nxt;
    logic [CW-1:0]     r_cnt,    w_cnt_nxt;
    logic [DW-1:0]     r_commit, w_commit_nxt;
    logic              r_cv,     w_cv_nxt;
    logic              r_rej,    w_rej_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_code;
        w_rel_nxt    = r_rel;
        w_buf_nxt    = r_buf;
        w_en_nxt     = r_en;
        w_cnt_nxt    = r_cnt;
        w_commit_nxt = r_commit;
        w_cv_nxt     = 1'b0;
        w_rej_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rel_nxt = '0;
                if (key_active && key_valid) begin
                    w_code_nxt  = key_code;
                    w_state_nxt = S_ACTION;
                end
            end
            S_ACTION: begin
                w_state_nxt = S_WAIT_REL;
                w_rel_nxt   = '0;
                // Function codes win over DEC_ONLY filtering; CLEAR > BACK > ENTER.
                if (r_code == KEY_CLEAR) begin
                    w_buf_nxt = '0;
                    w_en_nxt  = '0;
                    w_cnt_nxt = '0;
                end else if (r_code == KEY_BACK) begin
                    if (r_cnt != '0) begin
                        w_buf_nxt = r_buf >> 4;
                        w_en_nxt  = r_en >> 1;
                        w_cnt_nxt = r_cnt - CW'(1);
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end else if (r_code == KEY_ENTER) begin
                    if (r_cnt != '0) begin
                        w_commit_nxt = r_buf;
                        w_cv_nxt     = 1'b1;
                        w_buf_nxt    = '0;
                        w_en_nxt     = '0;
                        w_cnt_nxt    = '0;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end else if ((DEC_ONLY != 0) && (r_code > 4'd9)) begin
                    w_rej_nxt = 1'b1;
                end else if (r_cnt == CW'(NUM_DIGITS)) begin
                    w_rej_nxt = 1'b1;
                end else begin
                    w_buf_nxt = (r_buf << 4) | DW'(r_code);
                    w_en_nxt  = (r_en << 1) | NUM_DIGITS'(1);
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_REL: begin
                // Any activity restarts the release window; presses here are dropped.
                if (key_active) begin
                    w_rel_nxt = '0;
                end else if (r_rel == RW'(REL_CYCLES - 1)) begin
                    w_rel_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_rel_nxt = r_rel + RW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_code   <= '0;
            r_rel    <= '0;
            r_buf    <= '0;
            r_en     <= '0;
            r_cnt    <= '0;
            r_commit <= '0;
            r_cv     <= 1'b0;
            r_rej    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_code   <= w_code_nxt;
            r_rel    <= w_rel_nxt;
            r_buf    <= w_buf_nxt;
            r_en     <= w_en_nxt;
            r_cnt    <= w_cnt_nxt;
            r_commit <= w_commit_nxt;
            r_cv     <= w_cv_nxt;
            r_rej    <= w_rej_nxt;
        end
    end

    assign buf_data     = r_buf;
    assign buf_en       = r_en;
    assign count        = r_cnt;
    assign commit_data  = r_commit;
    assign commit_valid = r_cv;
    assign reject       = r_rej;
endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Scoreboard bench: two configurations (N=4 hex, N=1 decimal-only); every
// visible output change or pulse is popped from a queue of hand-computed events.
module tb_keypad_entry_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_act = 0, a_val = 0;
    logic [3:0]  a_code = 0;
    logic [15:0] a_bd, a_cd;
    logic [3:0]  a_be;
    logic [2:0]  a_cnt;
    logic        a_cv, a_rj;

    logic        b_act = 0, b_val = 0;
    logic [3:0]  b_code = 0;
    logic [3:0]  b_bd, b_cd;
    logic [0:0]  b_be;
    logic [0:0]  b_cnt;
    logic        b_cv, b_rj;

    keypad_entry_buffer #(.NUM_DIGITS(4), .REL_CYCLES(16), .DEC_ONLY(0)) dut_a (
        .clk(clk), .rst(rst), .key_active(a_act), .key_valid(a_val), .key_code(a_code),
        .buf_data(a_bd), .buf_en(a_be), .count(a_cnt), .commit_data(a_cd),
        .commit_valid(a_cv), .reject(a_rj));

    keypad_entry_buffer #(.NUM_DIGITS(1), .REL_CYCLES(4), .DEC_ONLY(1)) dut_b (
        .clk(clk), .rst(rst), .key_active(b_act), .key_valid(b_val), .key_code(b_code),
        .buf_data(b_bd), .buf_en(b_be), .count(b_cnt), .commit_data(b_cd),
        .commit_valid(b_cv), .reject(b_rj));

    typedef struct packed {
        logic [15:0] bd;
        logic [3:0]  be;
        logic [2:0]  cnt;
        logic [15:0] cd;
        logic        cv;
        logic        rj;
    } obs_t;

    obs_t a_obs, b_obs, a_prev, b_prev;
    assign a_obs = {a_bd, a_be, a_cnt, a_cd, a_cv, a_rj};
    assign b_obs = {12'h0, b_bd, 3'b0, b_be, 2'b0, b_cnt, 12'h0, b_cd, b_cv, b_rj};

    obs_t qa[$];
    obs_t qb[$];
    int   n_pass = 0, n_total = 0;
    bit   mon_en = 0;

    function automatic obs_t ex(input logic [15:0] bd, input logic [3:0] be,
                                input logic [2:0] cnt, input logic [15:0] cd,
                                input logic cv, input logic rj);
        obs_t r;
        r.bd = bd; r.be = be; r.cnt = cnt; r.cd = cd; r.cv = cv; r.rj = rj;
        return r;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got bd=%h be=%b cnt=%0d cd=%h cv=%b rj=%b, expected bd=%h be=%b cnt=%0d cd=%h cv=%b rj=%b",
                      name, act.bd, act.be, act.cnt, act.cd, act.cv, act.rj,
                      exp.bd, exp.be, exp.cnt, exp.cd, exp.cv, exp.rj);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic mon_step(input int id, input obs_t cur, input obs_t prev);
        obs_t e;
        if (cur.cv || cur.rj || cur.bd != prev.bd || cur.be != prev.be ||
            cur.cnt != prev.cnt || cur.cd != prev.cd) begin
            if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
                n_total++;
                $display("FAIL unexpected event inst %0d at %0t: bd=%h cnt=%0d cd=%h cv=%b rj=%b",
                         id, $time, cur.bd, cur.cnt, cur.cd, cur.cv, cur.rj);
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                chk((id == 0) ? "event inst A" : "event inst B", cur, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, a_obs, a_prev);
            mon_step(1, b_obs, b_prev);
        end
        a_prev <= a_obs;
        b_prev <= b_obs;
    end

    task automatic drive(input int id, input logic act, input logic val, input logic [3:0] code);
        if (id == 0) begin a_act = act; a_val = val; a_code = code; end
        else         begin b_act = act; b_val = val; b_code = code; end
    endtask

    task automatic press(input int id, input logic [3:0] code, input obs_t exp,
                         input bit has_exp, input int hold, input int rel);
        if (has_exp) begin
            if (id == 0) qa.push_back(exp); else qb.push_back(exp);
        end
        @(posedge clk); #1 drive(id, 1, 1, code);
        repeat (hold) @(posedge clk);
        #1 drive(id, 0, 0, 4'h0);
        repeat (rel) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("reset A", a_obs, ex(0, 0, 0, 0, 0, 0));
        chk("reset B", b_obs, ex(0, 0, 0, 0, 0, 0));
        mon_en = 1;

        // Fill, overflow, backspace, commit, empty commit
        press(0, 4'h1, ex(16'h0001, 4'b0001, 1, 0, 0, 0), 1, 50, 40);
        press(0, 4'h2, ex(16'h0012, 4'b0011, 2, 0, 0, 0), 1, 50, 40);
        press(0, 4'h3, ex(16'h0123, 4'b0111, 3, 0, 0, 0), 1, 50, 40);
        press(0, 4'h4, ex(16'h1234, 4'b1111, 4, 0, 0, 0), 1, 50, 40);
        press(0, 4'h5, ex(16'h1234, 4'b1111, 4, 0, 0, 1), 1, 50, 40);
        press(0, 4'hB, ex(16'h0123, 4'b0111, 3, 0, 0, 0), 1, 50, 40);
        press(0, 4'hB, ex(16'h0012, 4'b0011, 2, 0, 0, 0), 1, 50, 40);
        press(0, 4'hE, ex(16'h0000, 4'b0000, 0, 16'h0012, 1, 0), 1, 50, 40);
        press(0, 4'hE, ex(16'h0000, 4'b0000, 0, 16'h0012, 0, 1), 1, 50, 40);

        // Long hold with short release bounces and a different code mid-hold
        qa.push_back(ex(16'h0007, 4'b0001, 1, 16'h0012, 0, 0));
        @(posedge clk); #1 drive(0, 1, 1, 4'h7);
        for (int i = 0; i < 4; i++) begin
            repeat (100) @(posedge clk);
            #1 drive(0, 0, 0, 4'h0);
            repeat (5) @(posedge clk);
            #1 drive(0, 1, 1, 4'h8);
        end
        repeat (80) @(posedge clk);
        #1 drive(0, 0, 0, 4'h0);
        repeat (8) @(posedge clk);
        press(0, 4'h9, ex(0, 0, 0, 0, 0, 0), 0, 3, 40);
        press(0, 4'h8, ex(16'h0078, 4'b0011, 2, 16'h0012, 0, 0), 1, 50, 40);
        press(0, 4'hC, ex(16'h0000, 4'b0000, 0, 16'h0012, 0, 0), 1, 50, 40);
        press(0, 4'h3, ex(16'h0003, 4'b0001, 1, 16'h0012, 0, 0), 1, 50, 40);

        // Reset lands while ENTER is in ACTION: no commit, everything zeroed
        @(posedge clk); #1 drive(0, 1, 1, 4'hE);
        @(posedge clk); #1 begin
            rst = 1;
            drive(0, 0, 0, 4'h0);
            qa.push_back(ex(0, 0, 0, 0, 0, 0));
        end
        @(posedge clk); #1 rst = 0;
        repeat (10) @(posedge clk);

        // Two-cycle latency after reset; state must be IDLE again
        qa.push_back(ex(16'h0006, 4'b0001, 1, 0, 0, 0));
        @(posedge clk); #1 drive(0, 1, 1, 4'h6);
        @(posedge clk); @(negedge clk);
        chk_int("latency cnt after accept", a_cnt, 0);
        @(posedge clk); @(negedge clk);
        chk_int("latency cnt after action", a_cnt, 1);
        repeat (48) @(posedge clk);
        #1 drive(0, 0, 0, 4'h0);
        repeat (40) @(posedge clk);

        // Decimal-only single-digit instance
        press(1, 4'hA, ex(0, 0, 0, 0, 0, 1), 1, 20, 20);
        press(1, 4'h5, ex(4'h5, 1, 1, 0, 0, 0), 1, 20, 20);
        press(1, 4'h6, ex(4'h5, 1, 1, 0, 0, 1), 1, 20, 20);
        press(1, 4'hC, ex(0, 0, 0, 0, 0, 0), 1, 20, 20);
        press(1, 4'hE, ex(0, 0, 0, 0, 0, 1), 1, 20, 20);
        press(1, 4'h9, ex(4'h9, 1, 1, 0, 0, 0), 1, 20, 20);
        press(1, 4'hE, ex(0, 0, 0, 4'h9, 1, 0), 1, 20, 20);

        repeat (20) @(posedge clk);
        chk_int("pending events A", qa.size(), 0);
        chk_int("pending events B", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
